simplez_tx_port: RTL and testbench

Memory-mapped serial output port for the Simplez microcontroller: it decodes CPU bus accesses to the screen status and data addresses and serialises written characters as 8N1 UART frames on a single `tx` line. It sits on the CPU address/data bus, alongside main memory. Its read data is zero outside its two addresses, so it can be OR-ed with the memory output onto `busD`. It has a one-character holding register in front of a shift register, so the CPU can queue one character while another is on the wire.

---
 rtl/simplez_tx_port.sv | 212 +++++++++++++++++++++
 tb/tb_simplez_tx_port.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/simplez_tx_port.sv
// simplez_tx_port: memory-mapped UART transmitter for the Simplez CPU bus.
// One holding register feeds a shift register so the CPU can queue one
// character while another is on the wire. Status read: {ovr, ready}.
// Optional feature macro: SIMPLEZ_TX_PARITY_EN adds an even-parity bit (8E1).
// All state changes on the falling clock edge, in step with the CPU.
module simplez_tx_port #(
  parameter int              ADDRW       = 9,
  parameter int              DATAW       = 12,
  parameter int              BAUD_DIV    = 104,
  parameter logic [ADDRW-1:0] STATUS_ADDR = 9'd508,
  parameter logic [ADDRW-1:0] DATA_ADDR   = 9'd509
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADDRW-1:0] addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             tx,
  output logic             busy
);

  localparam int BCW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

`ifdef SIMPLEZ_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [BCW-1:0]   baudcnt_q, baudcnt_d;
  logic             ovr_q, ovr_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [DATAW-1:0] dout_q, dout_d;
`ifdef SIMPLEZ_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic baud_end, xfer, ovr_set, wr_data, rd_stat;

  // Upper data bits carry nothing for this port.
  logic unused_hi;
  assign unused_hi = ^data_in[DATAW-1:8];

  assign baud_end = (baudcnt_q == BCW'(BAUD_DIV - 1));
  assign wr_data  = wr && (addr == DATA_ADDR);
  assign rd_stat  = rd && (addr == STATUS_ADDR);

  // Next-state: frame sequencing, holding-register handshake, bus read mux.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    baudcnt_d   = baudcnt_q;
    ovr_d       = ovr_q;
    xfer        = 1'b0;
    ovr_set     = 1'b0;
`ifdef SIMPLEZ_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          xfer      = 1'b1;
          state_d   = START;
          baudcnt_d = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d   = DATA;
          baudcnt_d = '0;
          bitcnt_d  = '0;
        end else begin
          baudcnt_d = baudcnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baudcnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bitcnt_q == 3'd7) begin
`ifdef SIMPLEZ_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          baudcnt_d = baudcnt_q + 1'b1;
        end
      end
`ifdef SIMPLEZ_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d   = STOP;
          baudcnt_d = '0;
        end else begin
          baudcnt_d = baudcnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baudcnt_d = '0;
          // Chain straight into the next start bit when a character waits.
          if (hold_full_q) begin
            xfer    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudcnt_d = baudcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef SIMPLEZ_TX_PARITY_EN
      par_d       = ^hold_q;
`endif
    end

    // A write lands if the holder is empty or is being emptied this edge.
    if (wr_data) begin
      if (!hold_full_q || xfer) begin
        hold_d      = data_in[7:0];
        hold_full_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    // Clear-on-read, but a simultaneous overrun must not be lost.
    if (rd_stat) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef SIMPLEZ_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = hold_full_d | (state_d != IDLE);

    // Read data reflects pre-edge register values.
    dout_d = '0;
    if (addr == STATUS_ADDR) begin
      dout_d[1] = ovr_q;
      dout_d[0] = ~hold_full_q;
    end else if (addr == DATA_ADDR) begin
      dout_d[7:0] = hold_q;
    end
  end

  // State register, falling edge, synchronous active-low reset.
  always_ff @(negedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      baudcnt_q   <= '0;
      ovr_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      dout_q      <= '0;
`ifdef SIMPLEZ_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      baudcnt_q   <= baudcnt_d;
      ovr_q       <= ovr_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      dout_q      <= dout_d;
`ifdef SIMPLEZ_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_simplez_tx_port.sv
// Bench for simplez_tx_port: expected serial bits are queued when a character
// is written and compared by a line monitor as the frame appears on tx.
module tb_simplez_tx_port;
  localparam int ADDRW = 9;
  localparam int DATAW = 12;
  localparam int B     = 4;
  localparam logic [ADDRW-1:0] SA = 9'd508;
  localparam logic [ADDRW-1:0] DA = 9'd509;
`ifdef SIMPLEZ_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [ADDRW-1:0] addr;
  logic             wr, rd;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic             tx, busy;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic mon_act = 1'b0;

  simplez_tx_port #(.ADDRW(ADDRW), .DATAW(DATAW), .BAUD_DIV(B),
                    .STATUS_ADDR(SA), .DATA_ADDR(DA)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .wr(wr), .rd(rd),
    .data_in(data_in), .data_out(data_out), .tx(tx), .busy(busy));

  always #5 clk = ~clk;

  // DUT updates on negedge; the bench samples and drives on posedge.
  always @(posedge clk) begin
    if (exp_q.size() != 0 && (mon_act || tx === 1'b0)) begin
      logic e;
      e = exp_q.pop_front();
      checks++;
      assert (tx === e) else begin
        errors++;
        $error("FAIL tx_bit obs=%b exp=%b left=%0d", tx, e, exp_q.size());
      end
      mon_act = (exp_q.size() != 0);
    end
  end

  task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] c);
    for (int k = 0; k < B; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < B; k++) exp_q.push_back(c[i]);
`ifdef SIMPLEZ_TX_PARITY_EN
    for (int k = 0; k < B; k++) exp_q.push_back(^c);
`endif
    for (int k = 0; k < B; k++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_empty(input string tag, input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk(tag, DATAW'(exp_q.size()), '0);
    exp_q.delete();
    mon_act = 1'b0;
  endtask

  // Write one character from idle and measure how long busy stays high.
  task automatic send_measure(input string tag, input logic [7:0] c);
    int n;
    addr = DA; wr = 1'b1; data_in = {4'h0, c};
    push_frame(c);
    @(posedge clk);
    wr = 1'b0; addr = SA;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(posedge clk);
    end
    chk(tag, DATAW'(n), DATAW'(1 + FB * B));
    wait_empty({tag, "_q"}, 5);
  endtask

  initial begin
    rstn = 1'b0; wr = 1'b0; rd = 1'b0; addr = SA; data_in = '0;
    repeat (2) @(posedge clk);
    chk("rst_dout", data_out, 12'h000);
    chk("rst_tx", {11'b0, tx}, 12'h001);
    chk("rst_busy", {11'b0, busy}, 12'h000);

    rstn = 1'b1;
    @(posedge clk);
    chk("idle_status", data_out, 12'h001);
    chk("idle_tx", {11'b0, tx}, 12'h001);
    chk("idle_busy", {11'b0, busy}, 12'h000);

    addr = DA;
    @(posedge clk);
    chk("hold_rst", data_out, 12'h000);

    // Writes to the status address or elsewhere do nothing.
    addr = SA; wr = 1'b1; data_in = 12'hFFF;
    @(posedge clk);
    addr = 9'd3; data_in = 12'h0AB;
    @(posedge clk);
    wr = 1'b0; addr = SA;
    @(posedge clk);
    chk("ign_busy", {11'b0, busy}, 12'h000);
    @(posedge clk);
    chk("ign_status", data_out, 12'h001);
    addr = 9'd3;
    @(posedge clk);
    chk("other_addr", data_out, 12'h000);

    // Single frame 0x55.
    addr = DA; wr = 1'b1; data_in = 12'h055;
    push_frame(8'h55);
    @(posedge clk);
    wr = 1'b0; addr = SA;
    chk("w55_busy", {11'b0, busy}, 12'h001);
    @(posedge clk);
    chk("w55_held", data_out, 12'h000);
    @(posedge clk);
    chk("w55_ready", data_out, 12'h001);
    wait_empty("w55_done", 100);
    @(posedge clk);
    chk("w55_busy_end", {11'b0, busy}, 12'h000);
    chk("w55_tx_end", {11'b0, tx}, 12'h001);

    // Back-to-back 'A' then 'B'.
    addr = DA; wr = 1'b1; data_in = 12'h041;
    push_frame(8'h41);
    @(posedge clk);
    wr = 1'b0;
    repeat (10) @(posedge clk);
    addr = DA; wr = 1'b1; data_in = 12'h042;
    push_frame(8'h42);
    @(posedge clk);
    wr = 1'b0; addr = SA;
    @(posedge clk);
    chk("ab_held", data_out, 12'h000);
    begin
      int n;
      n = 0;
      while (data_out !== 12'h001 && n < 100) begin
        @(posedge clk);
        n++;
      end
      chk("ab_ready", data_out, 12'h001);
    end
    wait_empty("ab_done", 200);
    @(posedge clk);
    chk("ab_busy_end", {11'b0, busy}, 12'h000);

    // Overrun: third write hits a full holder.
    addr = DA; wr = 1'b1; data_in = 12'h011;
    push_frame(8'h11);
    @(posedge clk);
    data_in = 12'h022;
    push_frame(8'h22);
    @(posedge clk);
    data_in = 12'h033;
    @(posedge clk);
    wr = 1'b0; rd = 1'b1; addr = SA;
    @(posedge clk);
    chk("ovr_set", data_out, 12'h002);
    rd = 1'b0;
    @(posedge clk);
    chk("ovr_clr", data_out, 12'h000);
    addr = DA;
    @(posedge clk);
    chk("ovr_hold", data_out, 12'h022);
    addr = SA;
    wait_empty("ovr_done", 200);
    @(posedge clk);
    chk("ovr_busy_end", {11'b0, busy}, 12'h000);

    // Reset in the middle of data bit 1 abandons the frame.
    addr = DA; wr = 1'b1; data_in = 12'h00F;
    @(posedge clk);
    wr = 1'b0; addr = SA;
    repeat (9) @(posedge clk);
    chk("mid_busy", {11'b0, busy}, 12'h001);
    rstn = 1'b0;
    @(posedge clk);
    chk("mid_rst_tx", {11'b0, tx}, 12'h001);
    chk("mid_rst_busy", {11'b0, busy}, 12'h000);
    rstn = 1'b1;
    @(posedge clk);
    chk("mid_rst_status", data_out, 12'h001);
    send_measure("post_rst_len", 8'hA5);

`ifdef SIMPLEZ_TX_PARITY_EN
    send_measure("par07_len", 8'h07);
`endif
    send_measure("fc_len", 8'hFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
